multicycle_control_unit: RTL and testbench

- Multi-cycle FSM successor to the single-cycle combinational CU of the 24-bit CPU.
- Same instruction set: R-format, LS, SS, BEQ, ADDI.
- Sequences each instruction over FETCH/DECODE/EXEC/MEM/WB and waits on a memory ready handshake, with timeout.
- Sits between the instruction register and the datapath; drives the same control set plus PCWrite, IRWrite, illegal-op and timeout flags.

---
 rtl/multicycle_control_unit_if.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the instruction register,
// memory and datapath on one side and the multi-cycle control unit.
interface multicycle_control_unit_if #(
  parameter int OP_W = 4,
  parameter int FN_W = 4
);
  logic            Run;
  logic [OP_W-1:0] OPCODE;
  logic [FN_W-1:0] Funct;
  logic            mem_ready;
  logic            PCWrite;
  logic            IRWrite;
  logic            RegDst;
  logic            Branch;
  logic            MemRead;
  logic            MemToReg;
  logic [1:0]      AluOp;
  logic            MemWrite;
  logic            AluSrc;
  logic            RegWrite;
  logic            illegal_op;
  logic            mem_timeout;
  logic            busy;

  modport master (
    output Run, OPCODE, Funct, mem_ready,
    input  PCWrite, IRWrite, RegDst, Branch,
    input  MemRead, MemToReg, AluOp, MemWrite,
    input  AluSrc, RegWrite, illegal_op,
    input  mem_timeout, busy
  );

  modport slave (
    input  Run, OPCODE, Funct, mem_ready,
    output PCWrite, IRWrite, RegDst, Branch,
    output MemRead, MemToReg, AluOp, MemWrite,
    output AluSrc, RegWrite, illegal_op,
    output mem_timeout, busy
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 24-bit CPU: FETCH/DECODE/EXEC/MEM/WB
// with a bounded wait on the memory ready handshake.
module multicycle_control_unit #(
  parameter int              OP_W    = 4,
  parameter int              FN_W    = 4,
  parameter logic [OP_W-1:0] OP_R    = 4'b0110,
  parameter logic [OP_W-1:0] OP_LS   = 4'b0010,
  parameter logic [OP_W-1:0] OP_SS   = 4'b0011,
  parameter logic [OP_W-1:0] OP_BEQ  = 4'b0100,
  parameter logic [OP_W-1:0] OP_ADDI = 4'b0001,
  parameter logic [FN_W-1:0] FN_NOWB = 4'b0101,
  parameter int              TIMEOUT = 15
) (
  input logic                     Clock,
  input logic                     Reset,
  multicycle_control_unit_if.slave cu
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic [2:0]      state;
  logic [2:0]      stateNext;
  logic [2:0]      finish;
  logic [OP_W-1:0] opReg;
  logic [FN_W-1:0] fnReg;
  logic [7:0]      waitCnt;

  logic isR;
  logic isLs;
  logic isSs;
  logic isBeq;
  logic isAddi;
  logic noWb;
  logic liveLegal;
  logic inWait;
  logic expired;

  assign isR    = opReg == OP_R;
  assign isLs   = opReg == OP_LS;
  assign isSs   = opReg == OP_SS;
  assign isBeq  = opReg == OP_BEQ;
  assign isAddi = opReg == OP_ADDI;
  assign noWb   = fnReg == FN_NOWB;

  assign liveLegal = cu.OPCODE inside
    {OP_R, OP_LS, OP_SS, OP_BEQ, OP_ADDI};

  assign inWait  = (state == S_FETCH) ||
                   (state == S_MEM);
  // ready on the last allowed cycle still wins
  assign expired = inWait && !cu.mem_ready &&
                   (waitCnt == TO_CNT);
  assign finish  = cu.Run ? S_FETCH : S_IDLE;

  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE: begin
        if (cu.Run) stateNext = S_FETCH;
      end
      S_FETCH: begin
        if (cu.mem_ready)  stateNext = S_DECODE;
        else if (expired)  stateNext = S_IDLE;
      end
      S_DECODE: begin
        stateNext = liveLegal ? S_EXEC : finish;
      end
      S_EXEC: begin
        if (isBeq || (isR && noWb))
          stateNext = finish;
        else if (isLs || isSs)
          stateNext = S_MEM;
        else
          stateNext = S_WB;
      end
      S_MEM: begin
        if (cu.mem_ready)
          stateNext = isLs ? S_WB : finish;
        else if (expired)
          stateNext = S_IDLE;
      end
      S_WB: begin
        stateNext = finish;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      opReg   <= '0;
      fnReg   <= '0;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == S_DECODE) begin
        opReg <= cu.OPCODE;
        fnReg <= cu.Funct;
      end
      if ((stateNext != state) &&
          ((stateNext == S_FETCH) ||
           (stateNext == S_MEM)))
        waitCnt <= '0;
      else if (inWait && !cu.mem_ready)
        waitCnt <= waitCnt + 8'd1;
    end
  end

  always_comb begin
    cu.PCWrite     = 1'b0;
    cu.IRWrite     = 1'b0;
    cu.RegDst      = 1'b0;
    cu.Branch      = 1'b0;
    cu.MemRead     = 1'b0;
    cu.MemToReg    = 1'b0;
    cu.AluOp       = 2'b00;
    cu.MemWrite    = 1'b0;
    cu.AluSrc      = 1'b0;
    cu.RegWrite    = 1'b0;
    cu.illegal_op  = 1'b0;
    cu.mem_timeout = expired;
    cu.busy        = state != S_IDLE;
    unique case (state)
      S_FETCH: begin
        cu.MemRead = 1'b1;
        cu.IRWrite = 1'b1;
        cu.PCWrite = cu.mem_ready;
      end
      S_DECODE: begin
        cu.illegal_op = !liveLegal;
      end
      S_EXEC: begin
        unique case (1'b1)
          isR: cu.AluOp = noWb ? 2'b11 : 2'b10;
          isLs, isSs, isAddi: cu.AluSrc = 1'b1;
          isBeq: begin
            cu.Branch = 1'b1;
            cu.AluOp  = 2'b01;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        cu.AluSrc   = 1'b1;
        cu.MemRead  = isLs;
        cu.MemWrite = isSs;
      end
      S_WB: begin
        cu.RegWrite = 1'b1;
        cu.RegDst   = isR;
        cu.MemToReg = isLs;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each planned cycle pushes its expected control word,
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_control_unit;

  localparam int TO = 15;

  localparam int B_PC = 13, B_IR = 12, B_RD = 11, B_BR = 10;
  localparam int B_MRD = 9, B_M2R = 8, B_MW = 5, B_AS = 4;
  localparam int B_RW = 3, B_ILL = 2, B_TO = 1, B_BUSY = 0;

  typedef struct {
    bit         rst;
    bit         run;
    bit         mr;
    logic [3:0] op;
    logic [3:0] fn;
    logic [13:0] exp;
    int         ph;
  } cyc_t;

  logic Clock;
  logic Reset;
  multicycle_control_unit_if cu();

  multicycle_control_unit #(.TIMEOUT(TO)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .cu(cu.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  cyc_t expQ[$];
  int checks = 0;
  int errors = 0;
  bit nextIdle = 1'b1;
  cyc_t mc;
  logic [13:0] act;

  always @(negedge Clock) begin
    if (expQ.size() > 0) begin
      mc = expQ.pop_front();
      act = {cu.PCWrite, cu.IRWrite, cu.RegDst,
             cu.Branch, cu.MemRead, cu.MemToReg,
             cu.AluOp, cu.MemWrite, cu.AluSrc,
             cu.RegWrite, cu.illegal_op,
             cu.mem_timeout, cu.busy};
      checks++;
      if (act !== mc.exp) begin
        errors++;
        $display("FAIL ctl ph=%0d op=%h t=%0t got=%b want=%b",
                 mc.ph, mc.op, $time, act, mc.exp);
      end
    end
  end

  function automatic cyc_t mk(bit mr, logic [3:0] op,
                              logic [3:0] fn,
                              logic [13:0] e, int ph);
    cyc_t c;
    c.rst = 1'b0;
    c.run = 1'($urandom_range(0, 1));
    c.mr  = mr;
    c.op  = op;
    c.fn  = fn;
    c.exp = e;
    c.ph  = ph;
    return c;
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic drive(input cyc_t c);
    @(posedge Clock);
    #1;
    Reset        = c.rst;
    cu.Run       = c.run;
    cu.mem_ready = c.mr;
    cu.OPCODE    = c.op;
    cu.Funct     = c.fn;
    expQ.push_back(c);
  endtask

  // Plans one instruction from the ISA rules, then drives it.
  task automatic issue(input logic [3:0] op, input logic [3:0] fn,
                       input int fw, input int mw,
                       input bit runAfter, input bit rstInMem);
    cyc_t q[$];
    cyc_t c;
    logic [13:0] e;
    bit tout, isR, isLs, isSs, isBeq, isAddi, nowb;
    int n;
    tout = 1'b0;
    if (nextIdle) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        c = mk(1'($urandom_range(0, 1)), rnd4(), rnd4(), 14'd0, 0);
        c.run = (i == n - 1);
        q.push_back(c);
      end
    end
    e = '0;
    e[B_IR] = 1; e[B_MRD] = 1; e[B_BUSY] = 1;
    for (int i = 0; i <= TO; i++) begin
      if (fw > TO) begin
        c = mk(1'b0, rnd4(), rnd4(), e, 1);
        if (i == TO) begin
          c.exp[B_TO] = 1'b1;
          tout = 1'b1;
        end
        q.push_back(c);
      end else if (i < fw) begin
        q.push_back(mk(1'b0, rnd4(), rnd4(), e, 1));
      end else if (i == fw) begin
        c = mk(1'b1, rnd4(), rnd4(), e, 1);
        c.exp[B_PC] = 1'b1;
        q.push_back(c);
      end
    end
    isR = op == 4'b0110; isLs = op == 4'b0010;
    isSs = op == 4'b0011; isBeq = op == 4'b0100;
    isAddi = op == 4'b0001; nowb = isR && fn == 4'b0101;
    if (!tout) begin
      e = '0; e[B_BUSY] = 1;
      e[B_ILL] = !(isR || isLs || isSs || isBeq || isAddi);
      q.push_back(mk(1'($urandom_range(0, 1)), op, fn, e, 2));
      if (!e[B_ILL]) begin
        e = '0; e[B_BUSY] = 1;
        if (isR) e[7:6] = nowb ? 2'b11 : 2'b10;
        if (isLs || isSs || isAddi) e[B_AS] = 1;
        if (isBeq) begin e[B_BR] = 1; e[7:6] = 2'b01; end
        q.push_back(mk(1'($urandom_range(0, 1)), rnd4(), rnd4(), e, 3));
        if (isLs || isSs) begin
          e = '0; e[B_BUSY] = 1; e[B_AS] = 1;
          if (isLs) e[B_MRD] = 1; else e[B_MW] = 1;
          if (rstInMem) begin
            c = mk(1'b0, rnd4(), rnd4(), e, 4);
            c.rst = 1'b1;
            q.push_back(c);
            c = mk(1'b0, rnd4(), rnd4(), 14'd0, 0);
            c.run = 1'b0;
            q.push_back(c);
            tout = 1'b1;
          end else begin
            for (int i = 0; i <= TO; i++) begin
              if (mw > TO) begin
                c = mk(1'b0, rnd4(), rnd4(), e, 4);
                if (i == TO) begin
                  c.exp[B_TO] = 1'b1;
                  tout = 1'b1;
                end
                q.push_back(c);
              end else if (i < mw) begin
                q.push_back(mk(1'b0, rnd4(), rnd4(), e, 4));
              end else if (i == mw) begin
                q.push_back(mk(1'b1, rnd4(), rnd4(), e, 4));
              end
            end
          end
        end
        if (!tout && (isR && !nowb || isLs || isAddi)) begin
          e = '0; e[B_BUSY] = 1; e[B_RW] = 1;
          e[B_RD] = isR; e[B_M2R] = isLs;
          q.push_back(mk(1'($urandom_range(0, 1)), rnd4(), rnd4(), e, 5));
        end
      end
    end
    if (!tout) q[q.size() - 1].run = runAfter;
    nextIdle = tout || !runAfter;
    foreach (q[i]) drive(q[i]);
  endtask

  logic [3:0] legal [5];
  logic [3:0] rop, rfn;
  int r, rfw, rmw;

  initial begin
    legal[0] = 4'b0110; legal[1] = 4'b0010; legal[2] = 4'b0011;
    legal[3] = 4'b0100; legal[4] = 4'b0001;
    Reset = 1'b1;
    cu.Run = 1'b0;
    cu.mem_ready = 1'b0;
    cu.OPCODE = '0;
    cu.Funct = '0;
    repeat (2) @(posedge Clock);

    issue(4'b0110, 4'b0000, 0, 0, 1'b1, 1'b0);
    issue(4'b0010, 4'b1010, 0, 3, 1'b1, 1'b0);
    issue(4'b0100, 4'b0000, 0, 0, 1'b1, 1'b0);
    issue(4'b0110, 4'b0101, 0, 0, 1'b1, 1'b0);
    issue(4'b1111, 4'b0000, 0, 0, 1'b1, 1'b0);
    issue(4'b0001, 4'b0011, 0, 0, 1'b1, 1'b0);
    issue(4'b0110, 4'b0000, 16, 0, 1'b1, 1'b0);
    issue(4'b0010, 4'b0000, 0, 16, 1'b1, 1'b0);
    issue(4'b0011, 4'b0000, 15, 15, 1'b1, 1'b0);
    issue(4'b0001, 4'b0000, 1, 0, 1'b0, 1'b0);
    issue(4'b0011, 4'b0000, 0, 0, 1'b1, 1'b1);

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      rfn = rnd4();
      if (r < 5) rop = legal[r];
      else if (r == 5) begin rop = 4'b0110; rfn = 4'b0101; end
      else rop = rnd4();
      r = $urandom_range(0, 19);
      rfw = (r == 0) ? 16 : (r == 1) ? 15 : $urandom_range(0, 2);
      r = $urandom_range(0, 19);
      rmw = (r == 0) ? 16 : (r == 1) ? 15 : $urandom_range(0, 2);
      issue(rop, rfn, rfw, rmw,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0);
    end

    repeat (3) @(posedge Clock);
    if (checks < 12)
      $display("FAIL too few checks: %0d", checks);
    if (errors != 0)
      $display("FAIL %0d mismatches", errors);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
